// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcodes, instruction field positions and FSM state
//                encoding for the 16-bit CPU register-file sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction field positions: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Legal opcodes; 8..15 are illegal
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_LDI = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WAIT_RD  = 3'd2,
    ST_EXEC     = 3'd3,
    ST_WAIT_ALU = 3'd4,
    ST_WB       = 3'd5
  } state_t;

  // Source of the writeback data
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_RS   = 2'd2,
    WB_IMM  = 2'd3
  } wb_src_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rsc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rsc_decode
//  Description : Combinational opcode decoder for the register-file sequencer.
//                Classifies an opcode into ALU use, operand read, writeback
//                and writeback data source.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsc_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       needs_read,
  output logic       writes_rd,
  output logic       illegal,
  output wb_src_t    wb_src
);

  // Opcode classification; everything outside 0..7 is illegal
  always_comb begin
    is_alu     = 1'b0;
    needs_read = 1'b0;
    writes_rd  = 1'b0;
    illegal    = 1'b0;
    wb_src     = WB_NONE;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        is_alu     = 1'b1;
        needs_read = 1'b1;
        writes_rd  = 1'b1;
        wb_src     = WB_ALU;
      end
      OP_MOV: begin
        needs_read = 1'b1;
        writes_rd  = 1'b1;
        wb_src     = WB_RS;
      end
      OP_LDI: begin
        writes_rd  = 1'b1;
        wb_src     = WB_IMM;
      end
      OP_CMP: begin
        // Compare runs through the ALU but never writes a register
        is_alu     = 1'b1;
        needs_read = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : rsc_decode
`default_nettype wire

// File: rtl/regfile_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_seq_ctrl
//  Description : Multi-cycle sequencer between decode and the 4x16 register
//                file / ALU. Runs read -> execute -> writeback for one
//                instruction at a time, with a bounded wait on the register
//                file and ALU handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic          rf_en_in,
  output logic [1:0]    rf_rd,
  output logic [1:0]    rf_rs,
  input  logic          rf_en_out,
  input  logic [DW-1:0] rf_rd_q,
  input  logic [DW-1:0] rf_rs_q,
  output logic [3:0]    rf_reg_en,
  output logic [DW-1:0] rf_d_in,
  output logic          alu_start,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_out,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Last wait cycle index before the wait is abandoned
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    op_q;
  logic [1:0]    rd_q;
  logic [1:0]    rs_q;
  logic [7:0]    imm_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] res_q;
  logic [3:0]    alu_op_q;
  logic [7:0]    cnt_q;
  logic          err_q;
  logic          tmo_err;
  logic          accept;

  logic [3:0]    dec_opcode;
  logic          dec_is_alu;
  logic          dec_needs_read;
  logic          dec_writes_rd;
  logic          dec_illegal;
  wb_src_t       dec_wb_src;

  // In IDLE the decoder looks at the incoming word to pick the next state;
  // afterwards it looks at the latched opcode for the rest of the sequence.
  assign dec_opcode = (state == ST_IDLE) ? instr[OPC_MSB:OPC_LSB] : op_q;

  rsc_decode u_decode (
    .opcode     (dec_opcode),
    .is_alu     (dec_is_alu),
    .needs_read (dec_needs_read),
    .writes_rd  (dec_writes_rd),
    .illegal    (dec_illegal),
    .wb_src     (dec_wb_src)
  );

  assign accept    = instr_valid && instr_ready;
  assign rf_rd     = rd_q;
  assign rf_rs     = rs_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and output decode
  always_comb begin
    state_nxt   = state;
    tmo_err     = 1'b0;
    // Gated by rst so nothing advertises readiness while reset is held
    instr_ready = rst && (state == ST_IDLE);
    rf_en_in    = 1'b0;
    alu_start   = 1'b0;
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    rf_reg_en   = 4'b0000;
    rf_d_in     = '0;
    err         = err_q || (accept && dec_illegal);
    case (state)
      ST_IDLE: begin
        if (accept && !dec_illegal) begin
          state_nxt = dec_needs_read ? ST_READ : ST_WB;
        end
      end
      ST_READ: begin
        rf_en_in  = 1'b1;
        state_nxt = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (rf_en_out) begin
          state_nxt = dec_is_alu ? ST_EXEC : ST_WB;
        end else if (cnt_q == TO_LAST) begin
          state_nxt = ST_IDLE;
          tmo_err   = 1'b1;
        end
      end
      ST_EXEC: begin
        alu_start = 1'b1;
        state_nxt = ST_WAIT_ALU;
      end
      ST_WAIT_ALU: begin
        if (alu_done) begin
          state_nxt = ST_WB;
        end else if (cnt_q == TO_LAST) begin
          state_nxt = ST_IDLE;
          tmo_err   = 1'b1;
        end
      end
      ST_WB: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
        if (dec_writes_rd) rf_reg_en = 4'b0001 << rd_q;
        case (dec_wb_src)
          WB_ALU:  rf_d_in = res_q;
          WB_RS:   rf_d_in = b_q;
          WB_IMM:  rf_d_in = {{(DW-8){1'b0}}, imm_q};
          default: rf_d_in = '0;
        endcase
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch, operand/result capture and ALU operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= 4'd0;
      rd_q     <= 2'd0;
      rs_q     <= 2'd0;
      imm_q    <= 8'd0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      alu_op_q <= 4'd0;
    end else begin
      if (state == ST_IDLE && accept && !dec_illegal) begin
        op_q  <= instr[OPC_MSB:OPC_LSB];
        rd_q  <= instr[RD_MSB:RD_LSB];
        rs_q  <= instr[RS_MSB:RS_LSB];
        imm_q <= instr[IMM_MSB:IMM_LSB];
      end
      if (state == ST_WAIT_RD && rf_en_out) begin
        a_q <= rf_rd_q;
        b_q <= rf_rs_q;
        if (dec_is_alu) alu_op_q <= op_q;
      end
      if (state == ST_WAIT_ALU && alu_done) begin
        res_q <= alu_out;
      end
    end
  end

  // Wait counter: zero outside the wait states, so it starts at 0 on entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (state == ST_WAIT_RD || state == ST_WAIT_ALU) cnt_q <= cnt_q + 8'd1;
      else                                              cnt_q <= 8'd0;
      err_q <= tmo_err;
    end
  end

endmodule : regfile_seq_ctrl
`default_nettype wire
